// File: rtl/fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: generates RAM enables and
// addresses, tracks occupancy, and latches a sticky error on overflow/underflow.
module fifo_ctrl #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_BITS-1:0] addr_write,
    output logic [ADDR_BITS-1:0] addr_read,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 pop_valid,
    output logic                 error,
    output logic [1:0]           dbg_state
);

    // The word width belongs to the RAM; only a sanity hook references it here.
    if (DATA_BITS < 1) begin : g_invalid_data_bits
    end

    localparam logic [ADDR_BITS:0] DEPTH  = (ADDR_BITS + 1)'(1) << ADDR_BITS;
    localparam logic [ADDR_BITS:0] AF_CNT = AF_LEVEL[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AE_CNT = AE_LEVEL[ADDR_BITS:0];

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]   count_nxt;
    logic                 wr_ok, rd_ok, overflow, underflow;

    // Handshake: push/pop are single-cycle requests with no backpressure
    // signal; a request is either accepted in the cycle it is presented
    // (ram_write/ram_read high) or dropped. A popped word is valid on the
    // RAM output the cycle after, flagged by pop_valid.
    always_comb begin
        wr_ok     = 1'b0;
        rd_ok     = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        count_nxt = count;
        state_nxt = state;

        if (!reset && state != S_ERROR) begin
            wr_ok     = push & ((state != S_FULL) | pop);
            rd_ok     = pop & (state != S_EMPTY);
            overflow  = (state == S_FULL) & push & ~pop;
            underflow = (state == S_EMPTY) & pop;
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        // State follows the resulting occupancy unless an illegal request traps it.
        if (state == S_ERROR || overflow || underflow)
            state_nxt = S_ERROR;
        else if (count_nxt == '0)
            state_nxt = S_EMPTY;
        else if (count_nxt == DEPTH)
            state_nxt = S_FULL;
        else
            state_nxt = S_PARTIAL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            pop_valid    <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            full         <= (count_nxt == DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            pop_valid    <= rd_ok;
            error        <= (state_nxt == S_ERROR);
        end
    end

    assign ram_write  = wr_ok;
    assign ram_read   = rd_ok;
    assign addr_write = wr_ptr;
    assign addr_read  = rd_ptr;
    assign dbg_state  = state;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios then random traffic, checked against
// a queue-based occupancy model driving a small RAM.
module tb_fifo_ctrl;
  localparam int DW = 10;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic ram_write, ram_read, full, empty, almost_full, almost_empty, pop_valid, error;
  logic [AW-1:0] addr_write, addr_read;
  logic [AW:0] count;
  logic [1:0] dbg_state;

  fifo_ctrl #(.DATA_BITS(DW), .ADDR_BITS(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .ram_write(ram_write), .ram_read(ram_read),
    .addr_write(addr_write), .addr_read(addr_read),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .pop_valid(pop_valid), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle read latency; reading and writing one address returns the old word
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (ram_write) mem[addr_write] <= wdata;
    if (ram_read) rdata <= mem[addr_read];
  end

  // reference model
  logic [DW-1:0] exp_q[$];
  int wp = 0;
  int rp = 0;
  bit m_err = 0;
  bit m_pv = 0;
  logic [DW-1:0] m_data = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit p, input bit q, input bit r);
    bit a_push, a_pop, was_full, was_empty;
    @(negedge clk);
    push = p;
    pop = q;
    reset = r;
    wdata = DW'($urandom);
    was_full = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    a_push = !r && !m_err && p && (!was_full || q);
    a_pop = !r && !m_err && q && !was_empty;
    #1;
    chk("ram_write", 32'(ram_write), 32'(a_push));
    chk("ram_read", 32'(ram_read), 32'(a_pop));
    if (!r) begin
      chk("addr_write", 32'(addr_write), wp);
      chk("addr_read", 32'(addr_read), rp);
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      wp = 0;
      rp = 0;
      m_err = 0;
      m_pv = 0;
    end else begin
      if (a_pop) begin
        m_data = exp_q.pop_front();
        rp = (rp + 1) % DEPTH;
      end
      if (a_push) begin
        exp_q.push_back(wdata);
        wp = (wp + 1) % DEPTH;
      end
      m_pv = a_pop;
      if ((q && was_empty) || (p && !q && was_full)) m_err = 1;
    end
    #1;
    chk("count", 32'(count), exp_q.size());
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
    chk("error", 32'(error), 32'(m_err));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    if (m_pv) chk("pop_data", 32'(rdata), 32'(m_data));
  endtask

  initial begin
    bit r;
    int push_pct;

    // reset state
    step(0, 0, 1);
    step(0, 0, 1);

    // fill to full, write address wraps back to 0
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    // drain in order
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 0, 0);

    // underflow with simultaneous push
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);

    // full with push+pop for 3 cycles, then overflow
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // reset in the same cycle as a pop
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 0);

    // random traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      if (m_err) r = ($urandom_range(3) == 0);
      else r = ($urandom_range(79) == 0);
      push_pct = ((i / 40) % 2 == 0) ? 75 : 30;
      step($urandom_range(99) < push_pct, $urandom_range(99) >= push_pct, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
